pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage pipeline.
- Drives stall/flush of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register, plus the next-PC select.
- Resolves load-use hazards, EX-stage taken branches, ID-stage JAL redirects, variable-latency instruction fetch and data-memory busy.
- Tracks stale in-flight fetch responses after a redirect with a small state machine.

Parameters:
REG_ADDR_WIDTH, 5, register-file index width
PERF_CNT_WIDTH, 32, width of each performance counter (used only with the optional feature)

Ports:
cpu_clk  in  1  pipeline clock
cpu_rst  in  1  asynchronous, active-high reset
rs1_ID  in  REG_ADDR_WIDTH  rs1 index of the instruction in ID
rs2_ID  in  REG_ADDR_WIDTH  rs2 index of the instruction in ID
uses_rs1_ID  in  1  ID instruction reads rs1
uses_rs2_ID  in  1  ID instruction reads rs2
rd_EX  in  REG_ADDR_WIDTH  destination register of the instruction in EX
mem_read_EX  in  1  EX instruction is a load
branch_taken_EX  in  1  branch resolved taken in EX
jal_ID  in  1  JAL decoded in ID
imem_rsp_valid  in  1  instruction-memory response valid this cycle
dmem_busy  in  1  data memory not ready; freeze the pipeline
stall_PC  out  1  hold the PC register
stall_IF_ID  out  1  hold the IF/ID register
flush_IF_ID  out  1  clear the IF/ID register (bubble)
stall_ID_EX  out  1  hold the ID/EX register
flush_ID_EX  out  1  clear the ID/EX register
stall_EX_MEM  out  1  hold the EX/MEM register
redirect_sel  out  2  next-PC select: 00 = PC+4, 01 = JAL target, 10 = branch target
discard_o  out  1  high while in DISCARD state
stall_cnt  out  PERF_CNT_WIDTH  cycles with stall_PC=1 (optional feature)
flush_cnt  out  PERF_CNT_WIDTH  cycles with flush_IF_ID=1 (optional feature)

Behaviour:
- Clock and reset: one clock, cpu_clk, rising edge. cpu_rst is asynchronous and active-high.
- Only registered state: state {RUN, DISCARD} and the optional counters. All other outputs are combinational from state and inputs.
- While cpu_rst=1:
  - state=RUN, counters=0.
  - Outputs forced: stall_PC=1, flush_IF_ID=1, flush_ID_EX=1; all other outputs 0.
- First cycle after reset release: normal evaluation.
- Load-use hazard, lu = mem_read_EX & (rd_EX!=0) & ((uses_rs1_ID & rs1_ID==rd_EX) | (uses_rs2_ID & rs2_ID==rd_EX)).
- Priority per cycle, highest first; unlisted outputs are 0 and redirect_sel=00:
  1. dmem_busy=1:
     - stall_PC, stall_IF_ID, stall_ID_EX and stall_EX_MEM all 1; no flush.
     - state held; branch/jal/lu ignored this cycle (the stages are frozen and re-present them).
  2. branch_taken_EX=1:
     - flush_IF_ID=1, flush_ID_EX=1, redirect_sel=10.
     - Next state DISCARD if imem_rsp_valid=0 (old fetch still outstanding), else RUN. Applies in either state.
  3. state=DISCARD:
     - stall_PC=1, flush_IF_ID=1.
     - If imem_rsp_valid=1, that response is the stale one: drop it, next state RUN.
  4. lu=1: stall_PC=1, stall_IF_ID=1, flush_ID_EX=1. Exactly one bubble per load, because the load leaves EX next cycle.
  5. jal_ID=1:
     - flush_IF_ID=1, redirect_sel=01.
     - Next state DISCARD if imem_rsp_valid=0.
  6. imem_rsp_valid=0: stall_PC=1, flush_IF_ID=1 (fetch bubble).
  7. Otherwise all stalls/flushes 0, redirect_sel=00.
- Boundary cases:
  - A flush and a stall of the same register are never asserted together.
  - Reset asserted in DISCARD returns to RUN immediately, with no pending discard.
  - rd_EX=0 never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments every non-reset cycle with stall_PC=1.
  - flush_cnt increments every non-reset cycle with flush_IF_ID=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: the ports remain and are tied to 0, and no counter flops are generated.

Decomposition:
- Shared package, cpu_ctrl_pkg:
  - state encoding constants: ST_RUN=1'b0, ST_DISCARD=1'b1
  - redirect_sel constants: SEL_PC4=2'b00, SEL_JAL=2'b01, SEL_BR=2'b10
  - REG_ADDR_WIDTH default
- Natural sub-module: load_use_detect, the purely combinational lu comparator, reused by the forwarding unit.
- Counters stay inline.

Test Plan:
- Load-use: mem_read_EX=1, rd_EX=5, rs1_ID=5, uses_rs1_ID=1, imem_rsp_valid=1 -> exactly one cycle of stall_PC=1, stall_IF_ID=1, flush_ID_EX=1; following cycle (rd_EX changed) all 0.
- rd_EX=0 case: same stimulus with rd_EX=0 and rs1_ID=0 -> no stall.
- Branch with fetch complete: branch_taken_EX=1, imem_rsp_valid=1 -> flush_IF_ID=1, flush_ID_EX=1, redirect_sel=10; state stays RUN.
- Branch with fetch outstanding: branch_taken_EX=1, imem_rsp_valid=0 -> DISCARD; next 3 cycles imem_rsp_valid=0 -> stall_PC=1, flush_IF_ID=1, discard_o=1; when imem_rsp_valid=1 that cycle flush_IF_ID=1, then RUN; the following valid response is accepted.
- JAL vs load-use: jal_ID=1 with lu=1 -> load-use wins (stall_IF_ID=1, redirect_sel=00); next cycle jal_ID=1 alone -> flush_IF_ID=1, redirect_sel=01.
- Data-memory freeze: dmem_busy=1 for 4 cycles with branch_taken_EX=1 -> all four stalls 1, no flush, redirect_sel=00; on release the branch is acted on.
- Reset in DISCARD: cpu_rst pulsed mid-cycle while in DISCARD -> outputs take reset values immediately, state returns to RUN.
- Counters (HAZARD_PERF_CNT_EN defined): after the branch-with-fetch-outstanding scenario, stall_cnt=4 and flush_cnt=5.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state and next-PC select encodings for pipeline control.
package cpu_ctrl_pkg;
    localparam int REG_ADDR_WIDTH_DEF = 5;
    typedef enum logic {ST_RUN = 1'b0, ST_DISCARD = 1'b1} state_t;
    localparam logic [1:0] SEL_PC4 = 2'b00;
    localparam logic [1:0] SEL_JAL = 2'b01;
    localparam logic [1:0] SEL_BR  = 2'b10;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading the destination of a load in EX.
module load_use_detect #(
    parameter int REG_ADDR_WIDTH = cpu_ctrl_pkg::REG_ADDR_WIDTH_DEF
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_ID,
    input  logic                      uses_rs1_ID,
    input  logic                      uses_rs2_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rd_EX,
    input  logic                      mem_read_EX,
    output logic                      lu
);
    assign lu = mem_read_EX && (rd_EX != '0) &&
                ((uses_rs1_ID && rs1_ID == rd_EX) || (uses_rs2_ID && rs2_ID == rd_EX));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer with stale-fetch discard tracking.
// Optional performance counters enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic                      cpu_clk,
    input  logic                      cpu_rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_ID,
    input  logic                      uses_rs1_ID,
    input  logic                      uses_rs2_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rd_EX,
    input  logic                      mem_read_EX,
    input  logic                      branch_taken_EX,
    input  logic                      jal_ID,
    input  logic                      imem_rsp_valid,
    input  logic                      dmem_busy,
    output logic                      stall_PC,
    output logic                      stall_IF_ID,
    output logic                      flush_IF_ID,
    output logic                      stall_ID_EX,
    output logic                      flush_ID_EX,
    output logic                      stall_EX_MEM,
    output logic [1:0]                redirect_sel,
    output logic                      discard_o,
    output logic [PERF_CNT_WIDTH-1:0] stall_cnt,
    output logic [PERF_CNT_WIDTH-1:0] flush_cnt
);
    state_t state, state_nxt;
    logic   lu;

    load_use_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_lu (
        .rs1_ID      (rs1_ID),
        .rs2_ID      (rs2_ID),
        .uses_rs1_ID (uses_rs1_ID),
        .uses_rs2_ID (uses_rs2_ID),
        .rd_EX       (rd_EX),
        .mem_read_EX (mem_read_EX),
        .lu          (lu)
    );

    always_comb begin
        stall_PC     = 1'b0;
        stall_IF_ID  = 1'b0;
        flush_IF_ID  = 1'b0;
        stall_ID_EX  = 1'b0;
        flush_ID_EX  = 1'b0;
        stall_EX_MEM = 1'b0;
        redirect_sel = SEL_PC4;
        state_nxt    = state;
        if (cpu_rst) begin
            stall_PC    = 1'b1;
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (dmem_busy) begin
            stall_PC     = 1'b1;
            stall_IF_ID  = 1'b1;
            stall_ID_EX  = 1'b1;
            stall_EX_MEM = 1'b1;
        end else if (branch_taken_EX) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            redirect_sel = SEL_BR;
            state_nxt    = imem_rsp_valid ? ST_RUN : ST_DISCARD;
        end else if (state == ST_DISCARD) begin
            // a response arriving now belongs to the abandoned fetch
            stall_PC    = 1'b1;
            flush_IF_ID = 1'b1;
            state_nxt   = imem_rsp_valid ? ST_RUN : ST_DISCARD;
        end else if (lu) begin
            stall_PC    = 1'b1;
            stall_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (jal_ID) begin
            flush_IF_ID  = 1'b1;
            redirect_sel = SEL_JAL;
            state_nxt    = imem_rsp_valid ? ST_RUN : ST_DISCARD;
        end else if (!imem_rsp_valid) begin
            stall_PC    = 1'b1;
            flush_IF_ID = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst)
        if (cpu_rst) state <= ST_RUN;
        else         state <= state_nxt;

    assign discard_o = (state == ST_DISCARD);

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge cpu_clk or posedge cpu_rst)
        if (cpu_rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_PC && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_IF_ID && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks against a priority-rule model.
module tb_pipeline_hazard_ctrl;
    logic       cpu_clk = 1'b0;
    logic       cpu_rst;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic       uses_rs1_ID, uses_rs2_ID, mem_read_EX, branch_taken_EX, jal_ID;
    logic       imem_rsp_valid, dmem_busy;
    logic       stall_PC, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, stall_EX_MEM;
    logic [1:0] redirect_sel;
    logic       discard_o;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    bit m_disc = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipeline_hazard_ctrl dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
        .rd_EX(rd_EX), .mem_read_EX(mem_read_EX), .branch_taken_EX(branch_taken_EX),
        .jal_ID(jal_ID), .imem_rsp_valid(imem_rsp_valid), .dmem_busy(dmem_busy),
        .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .flush_IF_ID(flush_IF_ID),
        .stall_ID_EX(stall_ID_EX), .flush_ID_EX(flush_ID_EX), .stall_EX_MEM(stall_EX_MEM),
        .redirect_sel(redirect_sel), .discard_o(discard_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    wire [8:0] obs = {stall_PC, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX,
                      stall_EX_MEM, redirect_sel, discard_o};

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // which rule governs this cycle: 0 reset, 1 busy, 2 branch, 3 discard, 4 load-use, 5 jal, 6 fetch bubble, 7 idle
    function automatic int cause();
        bit hit = mem_read_EX && rd_EX != 0 &&
                  ((uses_rs1_ID && rs1_ID == rd_EX) || (uses_rs2_ID && rs2_ID == rd_EX));
        if (cpu_rst) return 0;
        if (dmem_busy) return 1;
        if (branch_taken_EX) return 2;
        if (m_disc) return 3;
        if (hit) return 4;
        if (jal_ID) return 5;
        if (!imem_rsp_valid) return 6;
        return 7;
    endfunction

    function automatic logic [8:0] expv(int c);
        logic d = m_disc;
        case (c)
            0: return 9'b1_0_1_0_1_0_00_0;
            1: return {8'b1_1_0_1_0_1_00, d};
            2: return {8'b0_0_1_0_1_0_10, d};
            3: return 9'b1_0_1_0_0_0_00_1;
            4: return {8'b1_1_0_0_1_0_00, d};
            5: return {8'b0_0_1_0_0_0_01, d};
            6: return {8'b1_0_1_0_0_0_00, d};
            default: return {8'b0, d};
        endcase
    endfunction

    task automatic drive(bit busy, bit br, bit jal, bit vld, bit mr, logic [4:0] rd,
                         logic [4:0] r1, bit u1, logic [4:0] r2, bit u2);
        dmem_busy = busy; branch_taken_EX = br; jal_ID = jal; imem_rsp_valid = vld;
        mem_read_EX = mr; rd_EX = rd; rs1_ID = r1; uses_rs1_ID = u1; rs2_ID = r2; uses_rs2_ID = u2;
    endtask

    task automatic step(string tag);
        int c;
        logic [8:0] e;
        #3;
        c = cause();
        e = expv(c);
        chk(tag, {23'b0, obs}, {23'b0, e});
`ifdef HAZARD_PERF_CNT_EN
        if (e[8]) m_stall++;
        if (e[6]) m_flush++;
`endif
        if (c == 2 || c == 3 || c == 5) m_disc = !imem_rsp_valid;
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        int exp_s, exp_f;
        cpu_rst = 1'b1;
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_out", {23'b0, obs}, {23'b0, expv(0)});
        chk("reset_cnt", stall_cnt | flush_cnt, 32'd0);
        @(negedge cpu_clk); @(negedge cpu_clk);
        cpu_rst = 1'b0;
        @(posedge cpu_clk); #1;
        drive(0, 0, 0, 1, 1, 5, 5, 1, 0, 0); step("lu");
        drive(0, 0, 0, 1, 1, 6, 5, 1, 0, 0); step("lu_after");
        drive(0, 0, 0, 1, 1, 0, 0, 1, 0, 0); step("lu_rd0");
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0); step("br_done");
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); step("br_done_run");
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); step("jal_out");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("in_discard", {31'b0, discard_o}, 32'd1);
        cpu_rst = 1'b1;
        #1;
        chk("rst_mid", {23'b0, obs}, {23'b0, expv(0)});
        cpu_rst = 1'b0;
        m_disc = 0; m_stall = 0; m_flush = 0;
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); step("br_out");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("disc_wait");
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); step("disc_drop");
        step("disc_accept");
`ifdef HAZARD_PERF_CNT_EN
        exp_s = 4; exp_f = 5;
`else
        exp_s = 0; exp_f = 0;
`endif
        chk("stall_cnt_br", stall_cnt, exp_s);
        chk("flush_cnt_br", flush_cnt, exp_f);
        drive(0, 0, 1, 1, 1, 5, 0, 0, 5, 1); step("jal_vs_lu");
        drive(0, 0, 1, 1, 0, 5, 0, 0, 5, 1); step("jal_alone");
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("busy_br");
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0); step("busy_release");
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); step("idle");
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(7) == 0, $urandom_range(5) == 0, $urandom_range(4) == 0,
                  $urandom_range(2) != 0, $urandom_range(1) == 1, 5'($urandom_range(3)),
                  5'($urandom_range(3)), $urandom_range(1) == 1, 5'($urandom_range(3)),
                  $urandom_range(1) == 1);
            step("rand");
        end
        chk("stall_cnt_end", stall_cnt, m_stall);
        chk("flush_cnt_end", flush_cnt, m_flush);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
